// File: rtl/fwrisc_exec_protocol_monitor.sv
// fwrisc_exec_protocol_monitor: issue-to-retire liveness, op legality and data-bus handshake checker
// with a sticky first-error code/cycle stamp and a saturating retire counter.
module fwrisc_exec_protocol_monitor #(
    parameter int          TIMEOUT_CYCLES  = 16,
    parameter logic [31:0] OP_TYPE_MASK    = 32'h0000_0001,
    parameter int          COMPLETE_TARGET = 8,
    parameter int          CNT_W           = 8,
    parameter bit          ASSERT_EN       = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             decode_valid,
    input  logic             instr_complete,
    input  logic [4:0]       op_type,
    input  logic             dvalid,
    input  logic             dready,
    output logic             busy,
    output logic [CNT_W-1:0] complete_cnt,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_cycle
);
    typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;
    state_t           state_q, state_d;
    logic [7:0]       lat_cnt_q, lat_cnt_d;
    logic [4:0]       op_q, op_d;
    logic             dvalid_q, dvalid_d, err_q, err_d;
    logic [2:0]       err_code_q, err_code_d, code;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, complete_cnt_q, complete_cnt_d, err_cycle_q, err_cycle_d;
    logic             idle, in_busy, retire, legal, ok, timeout;
    always_comb begin
        idle    = state_q == IDLE;
        in_busy = state_q == BUSY;
        retire  = instr_complete && (in_busy || (idle && decode_valid));
        // a zero-latency retire is judged on the op presented now, otherwise on the op captured at issue
        legal   = OP_TYPE_MASK[idle ? op_type : op_q];
        timeout = {1'b0, lat_cnt_q} + 9'd1 == 9'(TIMEOUT_CYCLES);
        code    = (state_q == ERROR)                          ? 3'd0 :
                  (idle && instr_complete && !decode_valid)   ? 3'd1 :
                  (in_busy && decode_valid && !instr_complete) ? 3'd2 :
                  (in_busy && !instr_complete && timeout)     ? 3'd3 :
                  (retire && !legal)                          ? 3'd4 :
                  (dvalid_q && !dvalid)                       ? 3'd5 :
                  (idle && dvalid && !decode_valid)           ? 3'd6 : 3'd0;
        ok      = state_q != ERROR && code == 3'd0;
        state_d = !ok ? ERROR :
                  idle ? ((decode_valid && !instr_complete) ? BUSY : IDLE) :
                  ((instr_complete && !decode_valid) ? IDLE : BUSY);
        lat_cnt_d      = !ok ? lat_cnt_q : decode_valid ? 8'd0 :
                         (in_busy && !instr_complete) ? lat_cnt_q + 8'd1 : lat_cnt_q;
        op_d           = (ok && decode_valid && (in_busy || !instr_complete)) ? op_type : op_q;
        complete_cnt_d = (ok && retire && !(&complete_cnt_q)) ? complete_cnt_q + CNT_W'(1) : complete_cnt_q;
        dvalid_d       = ok ? dvalid && !dready : dvalid_q;
        cycle_cnt_d    = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        err_d          = err_q || code != 3'd0;
        err_code_d     = code != 3'd0 ? code : err_code_q;
        err_cycle_d    = code != 3'd0 ? cycle_cnt_q : err_cycle_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            lat_cnt_q      <= '0;
            op_q           <= '0;
            dvalid_q       <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            cycle_cnt_q    <= '0;
            complete_cnt_q <= '0;
            err_cycle_q    <= '0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            op_q           <= op_d;
            dvalid_q       <= dvalid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            cycle_cnt_q    <= cycle_cnt_d;
            complete_cnt_q <= complete_cnt_d;
            err_cycle_q    <= err_cycle_d;
        end
    end
    assign busy         = state_q == BUSY;
    assign complete_cnt = complete_cnt_q;
    assign done         = int'(complete_cnt_q) >= COMPLETE_TARGET;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign err_cycle    = err_cycle_q;
    generate
        if (ASSERT_EN) begin : g_assert
            always_ff @(posedge clock) begin
                if (!reset) assert (!(err_d && !err_q));
            end
        end
    endgenerate
endmodule

// File: tb/tb_fwrisc_exec_protocol_monitor.sv
// tb_fwrisc_exec_protocol_monitor: directed scenarios plus random traffic against an
// issue/age/scoreboard model of the monitor's rules.
module tb_fwrisc_exec_protocol_monitor;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] MASK    = 32'h0000_0001;
    logic clock = 1'b0, reset = 1'b1;
    logic decode_valid = 1'b0, instr_complete = 1'b0, dvalid = 1'b0, dready = 1'b0;
    logic [4:0] op_type = '0;
    logic busy, done, err;
    logic [7:0] complete_cnt, err_cycle;
    logic [2:0] err_code;
    logic [21:0] dut_vec;
    int n_checks = 0, n_fail = 0;
    // reference model: in-flight flag, issue time, captured op, retire count, first error
    bit m_busy, m_err, m_pend;
    logic [4:0] m_op;
    int m_issue, m_count, m_cycle, m_ecycle, now;
    logic [2:0] m_code;

    fwrisc_exec_protocol_monitor #(
        .TIMEOUT_CYCLES(TIMEOUT), .OP_TYPE_MASK(MASK), .COMPLETE_TARGET(8), .CNT_W(8), .ASSERT_EN(0)
    ) dut (
        .clock(clock), .reset(reset), .decode_valid(decode_valid), .instr_complete(instr_complete),
        .op_type(op_type), .dvalid(dvalid), .dready(dready), .busy(busy), .complete_cnt(complete_cnt),
        .done(done), .err(err), .err_code(err_code), .err_cycle(err_cycle)
    );

    always #5 clock = ~clock;
    assign dut_vec = {busy, complete_cnt, done, err, err_code, err_cycle};

    function automatic logic [21:0] exp_vec();
        return {m_busy && !m_err, 8'(m_count), m_count >= 8, m_err, m_code, 8'(m_ecycle)};
    endfunction

    task automatic model_step(input logic dv, ic, input logic [4:0] op, input logic dval, drdy);
        int codes[$];
        logic ret;
        logic [4:0] rop;
        if (!m_err) begin
            ret = ic && (m_busy || dv);
            rop = m_busy ? m_op : op;
            if (!m_busy && ic && !dv) codes.push_back(1);
            if (m_busy && dv && !ic) codes.push_back(2);
            if (m_busy && !ic && now - m_issue == TIMEOUT) codes.push_back(3);
            if (ret && !MASK[rop]) codes.push_back(4);
            if (m_pend && !dval) codes.push_back(5);
            if (!m_busy && dval && !dv) codes.push_back(6);
            codes.sort();
            if (codes.size() > 0) begin
                m_err = 1; m_code = 3'(codes[0]); m_ecycle = m_cycle;
            end else begin
                if (ret && m_count < 255) m_count++;
                if (dv && !(ic && !m_busy)) begin
                    m_busy = 1; m_op = op; m_issue = now;
                end else if (ic) m_busy = 0;
                m_pend = dval && !drdy;
            end
        end
        m_cycle = m_cycle == 255 ? 255 : m_cycle + 1;
        now++;
    endtask

    task automatic drive(input logic dv, ic, input logic [4:0] op, input logic dval, drdy);
        decode_valid = dv; instr_complete = ic; op_type = op; dvalid = dval; dready = drdy;
        @(posedge clock);
        model_step(dv, ic, op, dval, drdy);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; decode_valid = 0; instr_complete = 0; op_type = 0; dvalid = 0; dready = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        m_busy = 0; m_err = 0; m_pend = 0; m_op = 0; m_issue = 0; m_count = 0;
        m_cycle = 0; m_ecycle = 0; m_code = 0; now = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== 22'd0) begin n_fail++; $display("FAIL reset got %h want 0", dut_vec); end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(c == 2, c == 5, 5'd0, 0, 0);
            n_checks++;
            if (busy !== (c >= 2 && c <= 4)) begin n_fail++; $display("FAIL single_busy c%0d got %b", c, busy); end
            n_checks++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL single c%0d got %h want %h", c, dut_vec, exp_vec()); end
        end
        n_checks++;
        if (complete_cnt !== 8'd1 || err !== 1'b0) begin
            n_fail++; $display("FAIL single_end cnt=%0d err=%b want 1/0", complete_cnt, err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 5'd0, 0, 0);
            n_checks++;
            if (done !== (i == 8) || complete_cnt !== 8'(i) || err !== 1'b0) begin
                n_fail++; $display("FAIL b2b i%0d done=%b cnt=%0d err=%b", i, done, complete_cnt, err);
            end
        end
        drive(1, 0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 5'd0, 0, 0);
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (dut_vec !== exp_vec() || complete_cnt !== 8'd12 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_busy got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 0, 5'd0, 0, 0);
        drive(1, 0, 5'd0, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            drive(0, 0, 5'd0, 0, 0);
            n_checks++;
            if (err !== (k >= 16)) begin n_fail++; $display("FAIL timeout_edge k%0d err=%b", k, err); end
        end
        n_checks++;
        if (err_code !== 3'd3 || err_cycle !== 8'd17 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout code=%0d cyc=%0d busy=%b want 3/17/0", err_code, err_cycle, busy);
        end
        do_reset();
        drive(1, 0, 5'd0, 0, 0);
        repeat (15) drive(0, 0, 5'd0, 0, 0);
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (err !== 1'b0 || complete_cnt !== 8'd1) begin
            n_fail++; $display("FAIL timeout_limit err=%b cnt=%0d want 0/1", err, complete_cnt);
        end
    endtask

    task automatic test_illegal_op();
        do_reset();
        drive(1, 0, 5'd2, 0, 0);
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd4 || complete_cnt !== 8'd0 || err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_op code=%0d cnt=%0d want 4/0", err_code, complete_cnt);
        end
        do_reset();
        drive(1, 1, 5'd3, 0, 0);
        n_checks++;
        if (err_code !== 3'd4 || err_cycle !== 8'd0) begin
            n_fail++; $display("FAIL illegal_zero code=%0d cyc=%0d want 4/0", err_code, err_cycle);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        for (int c = 0; c < 5; c++) drive(0, c == 4, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd1 || err_cycle !== 8'd4) begin
            n_fail++; $display("FAIL spurious code=%0d cyc=%0d want 1/4", err_code, err_cycle);
        end
        do_reset();
        drive(0, 1, 5'd0, 1, 0);
        n_checks++;
        if (err_code !== 3'd1) begin n_fail++; $display("FAIL prio_1v6 code=%0d want 1", err_code); end
        do_reset();
        drive(1, 0, 5'd0, 1, 0);
        drive(1, 0, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd2) begin n_fail++; $display("FAIL prio_2v5 code=%0d want 2", err_code); end
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd2 || complete_cnt !== 8'd0) begin
            n_fail++; $display("FAIL sticky code=%0d cnt=%0d want 2/0", err_code, complete_cnt);
        end
        do_reset();
        drive(0, 0, 5'd0, 1, 0);
        n_checks++;
        if (err_code !== 3'd6) begin n_fail++; $display("FAIL stray code=%0d want 6", err_code); end
    endtask

    task automatic test_dbus();
        do_reset();
        drive(1, 0, 5'd0, 0, 0);
        drive(0, 0, 5'd0, 1, 0);
        drive(0, 0, 5'd0, 1, 0);
        drive(0, 0, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd5 || err_cycle !== 8'd3) begin
            n_fail++; $display("FAIL dbus_drop code=%0d cyc=%0d want 5/3", err_code, err_cycle);
        end
        do_reset();
        drive(1, 0, 5'd0, 0, 0);
        drive(0, 0, 5'd0, 1, 0);
        drive(0, 0, 5'd0, 1, 1);
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (err !== 1'b0 || complete_cnt !== 8'd1) begin
            n_fail++; $display("FAIL dbus_ok err=%b cnt=%0d want 0/1", err, complete_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 5'd0, 0, 0);
        drive(0, 0, 5'd0, 0, 0);
        do_reset();
        n_checks++;
        if (dut_vec !== 22'd0) begin n_fail++; $display("FAIL reset_mid got %h want 0", dut_vec); end
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd1 || err_cycle !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid_spur code=%0d cyc=%0d want 1/0", err_code, err_cycle);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (260) drive(1, 1, 5'd0, 0, 0);
        n_checks++;
        if (complete_cnt !== 8'd255 || done !== 1'b1) begin
            n_fail++; $display("FAIL sat_cnt cnt=%0d done=%b want 255/1", complete_cnt, done);
        end
        drive(0, 1, 5'd0, 0, 0);
        n_checks++;
        if (err_code !== 3'd1 || err_cycle !== 8'd255 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL sat_cycle got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic dv, ic, dval, drdy;
        logic [4:0] op;
        for (int e = 0; e < 25; e++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                dv   = $urandom_range(0, 9) < 4;
                ic   = $urandom_range(0, 9) < 4;
                op   = $urandom_range(0, 15) == 0 ? 5'($urandom_range(0, 31)) : 5'd0;
                dval = $urandom_range(0, 19) < (m_busy ? 6 : 1);
                drdy = $urandom_range(0, 1) == 1;
                drive(dv, ic, op, dval, drdy);
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL random e%0d c%0d got %h want %h", e, c, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_illegal_op();
        test_spurious();
        test_dbus();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
